// File: rtl/jtag_master_sched.sv
`default_nettype none
// ============================================================================
// Module   : jtag_master_sched
// Purpose  : Two-port JTAG command scheduler driving registered TCK/TMS/TDI
//            and capturing TDO. Optional macro JTAG_SCHED_ROUND_ROBIN_EN
//            selects round-robin arbitration instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_master_sched #(
    parameter int TCK_HALF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][2:0]  req_cmd,
    input  logic [1:0][5:0]  req_nbits,
    input  logic [1:0][31:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic             tck,
    output logic             tms,
    output logic             tdi,
    input  logic             tdo
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SHIFT_LO = 2'd1;
    localparam logic [1:0] c_SHIFT_HI = 2'd2;
    localparam logic [1:0] c_RESP     = 2'd3;

    localparam logic [2:0] c_CMD_RESET = 3'd0;
    localparam logic [2:0] c_CMD_TMS   = 3'd1;
    localparam logic [2:0] c_CMD_SCAN  = 3'd2;
    localparam logic [2:0] c_CMD_FLIP  = 3'd3;

    localparam logic [7:0] c_HALF_LAST = 8'(TCK_HALF_DIV - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  half_cnt_q, half_cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  last_bit_q, last_bit_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic        id_q, id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        err_q, err_d;
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;

    logic        w_grant;
    logic        w_grant_id;
    logic [2:0]  w_cmd;
    logic [5:0]  w_nbits;
    logic [31:0] w_data;
    logic        w_legal;
    logic [5:0]  w_last;

    // Returns {tms, tdi} for bit idx of a command.
    function automatic logic [1:0] pin_bits(input logic [2:0] cmd, input logic [31:0] data,
                                            input logic [5:0] idx, input logic [5:0] last);
        logic [1:0] r;
        r = 2'b00;
        case (cmd)
            c_CMD_RESET: r[1] = (idx < 6'd5);
            c_CMD_TMS:   r[1] = data[idx[4:0]];
            c_CMD_SCAN:  r[0] = data[idx[4:0]];
            c_CMD_FLIP: begin
                r[1] = (idx == last);
                r[0] = data[idx[4:0]];
            end
            default:     r = 2'b00;
        endcase
        return r;
    endfunction

`ifdef JTAG_SCHED_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    always_comb begin
        if (&req_valid) w_grant_id = ptr_q;
        else            w_grant_id = ~req_valid[0];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_grant) ptr_d = ~w_grant_id;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`else
    assign w_grant_id = ~req_valid[0];
`endif

    assign w_grant = (state_q == c_IDLE) & enable & (|req_valid) & ~rst;
    assign w_cmd   = req_cmd[w_grant_id];
    assign w_nbits = req_nbits[w_grant_id];
    assign w_data  = req_data[w_grant_id];
    assign w_legal = (w_cmd == c_CMD_RESET) |
                     ((w_cmd <= c_CMD_FLIP) & (w_nbits != 6'd0) & (w_nbits <= 6'd32));
    assign w_last  = (w_cmd == c_CMD_RESET) ? 6'd5 : (w_nbits - 6'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            last_bit_q <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        case (state_q)
            c_IDLE: begin
                if (w_grant) begin
                    id_d       = w_grant_id;
                    cmd_d      = w_cmd;
                    data_d     = w_data;
                    last_bit_d = w_last;
                    rsp_data_d = '0;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    err_d      = ~w_legal;
                    if (w_legal) begin
                        state_d        = c_SHIFT_LO;
                        {tms_d, tdi_d} = pin_bits(w_cmd, w_data, 6'd0, w_last);
                    end else begin
                        state_d = c_RESP;
                    end
                end
            end
            c_SHIFT_LO: begin
                if (half_cnt_q == c_HALF_LAST) begin
                    state_d    = c_SHIFT_HI;
                    half_cnt_d = '0;
                    tck_d      = 1'b1;
                    // Only scan commands report TDO; the others return zero.
                    if (cmd_q[1]) rsp_data_d[bit_cnt_q[4:0]] = tdo;
                end else begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end
            end
            c_SHIFT_HI: begin
                if (half_cnt_q == c_HALF_LAST) begin
                    half_cnt_d = '0;
                    tck_d      = 1'b0;
                    if (bit_cnt_q == last_bit_q) begin
                        state_d = c_RESP;
                        tms_d   = 1'b0;
                        tdi_d   = 1'b0;
                    end else begin
                        state_d        = c_SHIFT_LO;
                        bit_cnt_d      = bit_cnt_q + 6'd1;
                        {tms_d, tdi_d} = pin_bits(cmd_q, data_q, bit_cnt_q + 6'd1, last_bit_q);
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end
            end
            default: begin
                if (rsp_ready) state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (w_grant) req_ready = w_grant_id ? 2'b10 : 2'b01;
        rsp_valid = (state_q == c_RESP);
        rsp_id    = id_q;
        rsp_data  = rsp_data_q;
        rsp_err   = err_q;
        tck       = tck_q;
        tms       = tms_q;
        tdi       = tdi_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_master_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_jtag_master_sched
// Purpose  : Randomized scoreboard bench for jtag_master_sched with a
//            command-level reference model (honours JTAG_SCHED_ROUND_ROBIN_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_master_sched;

    localparam int H = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][2:0]  req_cmd = '0;
    logic [1:0][5:0]  req_nbits = '0;
    logic [1:0][31:0] req_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             tck, tms, tdi;
    logic             tdo;
    logic             inv = 1'b0;

    assign tdo = tdi ^ inv;

    always #5 clk = ~clk;

    jtag_master_sched #(.TCK_HALF_DIV(H)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_nbits(req_nbits), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] data;
        int          n;
        logic [63:0] tms;
        logic [63:0] tdi;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        rst_s = 1'b0;
    logic        busy = 1'b0;
    int          pref = 0;
    int          n_acc = 0;
    logic        fix_inv = 1'b0;
    int          obs_n = 0;
    logic [63:0] obs_tms = '0;
    logic [63:0] obs_tdi = '0;
    int          lat_meas = -1;
    logic        p_tck = 1'b0, p_rv = 1'b0, p_rr = 1'b0, p_id = 1'b0, p_err = 1'b0;
    logic [31:0] p_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Command-level reference: pin sequences, response data and latency.
    function automatic exp_t model(input logic id, input logic [2:0] c, input logic [5:0] n,
                                   input logic [31:0] d, input logic iv, input int acc);
        exp_t        e;
        logic [31:0] m;
        e.id = id; e.err = 1'b0; e.data = '0; e.n = 0; e.tms = '0; e.tdi = '0; e.acc = acc;
        m = (n >= 6'd32) ? 32'hFFFF_FFFF : 32'((64'd1 << n) - 64'd1);
        if (c > 3'd3 || (c != 3'd0 && (n == 6'd0 || n > 6'd32))) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        case (c)
            3'd0: begin e.n = 6; e.tms = 64'h1F; end
            3'd1: begin e.n = int'(n); e.tms = 64'(d & m); end
            3'd2: begin e.n = int'(n); e.tdi = 64'(d & m); e.data = (d ^ {32{iv}}) & m; end
            default: begin
                e.n = int'(n); e.tdi = 64'(d & m); e.data = (d ^ {32{iv}}) & m;
                e.tms = 64'd1 << (n - 6'd1);
            end
        endcase
        e.lat = 1 + 2 * H * e.n;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    // Monitor: grant checking, pin observation and response scoreboard.
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        int         g;
        exp_t       e;
        if (rst_s) begin
            sb.delete();
            busy = 1'b0; pref = 0; obs_n = 0; p_rv = 1'b0; p_rr = 1'b0; p_tck = 1'b0;
            check("rst_pins", 64'({tck, tms, tdi}), 64'd0);
            check("rst_rsp", 64'({rsp_valid, rsp_id, rsp_err, rsp_data}), 64'd0);
        end
        if (!busy || rsp_valid) check("pins_idle", 64'({tck, tms, tdi}), 64'd0);
        if (!busy) check("idle_rsp", 64'(rsp_valid), 64'd0);
        if (tck && !p_tck) begin
            if (obs_n < 64) begin
                obs_tms[obs_n] = tms;
                obs_tdi[obs_n] = tdi;
            end
            obs_n++;
        end
        if (p_rv && !p_rr)
            check("rsp_hold", 64'({rsp_valid, rsp_id, rsp_err, rsp_data}),
                  64'({1'b1, p_id, p_err, p_data}));
        if (rsp_valid && !p_rv && sb.size() > 0) lat_meas = cyc - sb[0].acc;

        exp_rdy = 2'b00;
        g = 0;
        if (!busy && enable && !rst && (|req_valid)) begin
`ifdef JTAG_SCHED_ROUND_ROBIN_EN
            g = (&req_valid) ? pref : (req_valid[0] ? 0 : 1);
`else
            g = req_valid[0] ? 0 : 1;
`endif
            exp_rdy = 2'b01 << g;
        end
        check("grant", 64'(req_ready), 64'(exp_rdy));
        if (exp_rdy != 2'b00 && req_ready == exp_rdy) begin
            inv = fix_inv ? 1'b0 : 1'($urandom);
            sb.push_back(model(1'(g), req_cmd[g], req_nbits[g], req_data[g], inv, cyc));
            busy = 1'b1; pref = 1 - g; obs_n = 0; obs_tms = '0; obs_tdi = '0;
            lat_meas = -1; n_acc++;
        end

        if (rsp_valid && rsp_ready && busy) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("tck_pulses", 64'(obs_n), 64'(e.n));
                check("tms_seq", obs_tms, e.tms);
                check("tdi_seq", obs_tdi, e.tdi);
                check("latency", 64'(lat_meas), 64'(e.lat));
            end
            busy = 1'b0;
        end
        p_tck = tck; p_rv = rsp_valid; p_rr = rsp_ready;
        p_id = rsp_id; p_err = rsp_err; p_data = rsp_data;
    end

    task automatic rand_cmd(input int p);
        int r;
        r = int'($urandom % 10);
        req_cmd[p]   = (r < 8) ? 3'(r % 4) : 3'(4 + $urandom % 4);
        if ($urandom % 6 == 0) req_nbits[p] = ($urandom % 2 == 0) ? 6'd0 : 6'd32;
        else                   req_nbits[p] = 6'(1 + $urandom % 32);
        req_data[p]  = $urandom;
    endtask

    task automatic run_random(input int cycles, input bit sat);
        int         wait_c[2];
        int         hold;
        logic [1:0] got;
        wait_c[0] = 0; wait_c[1] = 0; hold = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && got[p]) begin
                    if (sat) rand_cmd(p);
                    else begin
                        req_valid[p] = 1'b0;
                        wait_c[p]    = int'($urandom % 6);
                    end
                end else if (!req_valid[p]) begin
                    if (wait_c[p] == 0) begin
                        rand_cmd(p);
                        req_valid[p] = 1'b1;
                    end else wait_c[p]--;
                end
            end
            if (sat) begin
                enable = 1'b1; rsp_ready = 1'b1;
            end else begin
                enable = ($urandom % 12) != 0;
                if (hold > 0) begin rsp_ready = 1'b0; hold--; end
                else if ($urandom % 16 == 0) begin rsp_ready = 1'b0; hold = 10; end
                else rsp_ready = ($urandom % 4) != 0;
            end
        end
    endtask

    task automatic drain();
        int t;
        @(posedge clk);
        #1;
        req_valid = 2'b00; rsp_ready = 1'b1; enable = 1'b1;
        t = 0;
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("drain_timeout", 64'd1, 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic issue(input int p, input logic [2:0] c, input logic [5:0] n,
                         input logic [31:0] d, input int hold);
        int t;
        @(posedge clk);
        #1;
        req_cmd[p] = c; req_nbits[p] = n; req_data[p] = d; req_valid[p] = 1'b1;
        rsp_ready = (hold == 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[p] && t < 200);
        if (!req_ready[p]) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
        if (hold > 0) begin
            req_cmd[1 - p] = 3'd1; req_nbits[1 - p] = 6'd3; req_valid[1 - p] = 1'b1;
            t = 0;
            while (!rsp_valid && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!rsp_valid) check("rsp_timeout", 64'd1, 64'd0);
            repeat (hold) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
        end
        drain();
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; enable = 1'b1;
        run_random(3000, 1'b0);
        drain();
        run_random(600, 1'b1);
        drain();
        fix_inv = 1'b1;
        issue(0, 3'd0, 6'd6, 32'h0, 0);
        issue(0, 3'd2, 6'd8, 32'hA5, 0);
        issue(1, 3'd3, 6'd32, 32'hFFFF_FFFF, 0);
        issue(1, 3'd2, 6'd0, 32'h1234, 0);
        issue(0, 3'd5, 6'd8, 32'h5678, 10);
        issue(1, 3'd1, 6'd32, 32'hC3A5_0F1E, 0);

        // Abort a scan mid-command with reset while TCK is high.
        @(posedge clk);
        #1;
        req_cmd[0] = 3'd2; req_nbits[0] = 6'd16; req_data[0] = 32'hBEEF; req_valid[0] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[0] && t < 200);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!tck && t < 200);
        if (!tck) check("tck_timeout", 64'd1, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) @(posedge clk);

        check("accepted_any", 64'(n_acc > 20), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
